// File: rtl/present80_iter_core.sv
// PRESENT-80 block cipher, iterative core: one round per clock, or two per clock
// when PRESENT80_UNROLL2_EN is defined. Ciphertext is identical in both builds.
module present80_iter_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] pt,
    input  logic [79:0] key,
    output logic        busy,
    output logic        done,
    output logic [63:0] ct
);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] keyreg_q, keyreg_d;
    logic [4:0]  rc_q, rc_d;
    logic        busy_d, done_d;
    logic [63:0] ct_d;
    logic [63:0] s1;
    logic [79:0] k1;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] o;
        for (int n = 0; n < 16; n++)
            o[4*n +: 4] = sbox4(s[4*n +: 4]);
        return o;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 is the fixed point of the permutation.
    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 63; i++)
            o[(16 * i) % 63] = s[i];
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [63:0] round_state(input logic [63:0] s, input logic [79:0] k);
        return p_layer(sbox_layer(s ^ k[79:16]));
    endfunction

    // Rotate left by 61, S-box the top nibble, fold the round counter into bits 19:15.
    function automatic logic [79:0] key_next(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox4(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        fsm_d    = fsm_q;
        state_d  = state_q;
        keyreg_d = keyreg_q;
        rc_d     = rc_q;
        busy_d   = busy;
        done_d   = 1'b0;
        ct_d     = ct;
        s1       = round_state(state_q, keyreg_q);
        k1       = key_next(keyreg_q, rc_q);

        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d    = RUN;
                    state_d  = pt;
                    keyreg_d = key;
                    rc_d     = 5'd1;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                state_d  = s1;
                keyreg_d = k1;
                rc_d     = rc_q + 5'd1;
`ifdef PRESENT80_UNROLL2_EN
                // Round 31 is odd, so the last edge runs a single round.
                if (rc_q != 5'd31) begin
                    state_d  = round_state(s1, k1);
                    keyreg_d = key_next(k1, rc_q + 5'd1);
                    rc_d     = rc_q + 5'd2;
                end
`endif
                if (rc_q == 5'd31) begin
                    fsm_d  = IDLE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    ct_d   = s1 ^ k1[79:16];
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            keyreg_q <= '0;
            rc_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ct       <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            keyreg_q <= keyreg_d;
            rc_q     <= rc_d;
            busy     <= busy_d;
            done     <= done_d;
            ct       <= ct_d;
        end
    end

endmodule

// File: tb/tb_present80_iter_core.sv
// Scoreboard bench for present80_iter_core: stimulus pushes expected ciphertexts,
// a monitor pops and compares on every done pulse. Honours PRESENT80_UNROLL2_EN.
`timescale 1ns/1ps
module tb_present80_iter_core;

`ifdef PRESENT80_UNROLL2_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 31;
`endif
    localparam int PER = LAT + 1;

    localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
    localparam logic [63:0] CT_0F = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_F0 = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT_FF = 64'h3333DCD3213210D2;
    localparam logic [63:0] ONES64 = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [79:0] ONES80 = 80'hFFFFFFFFFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [63:0] pt, ct;
    logic [79:0] key;

    int          n_cmp = 0, n_err = 0, n_done = 0, n_push = 0;
    logic [63:0] exp_q[$];

    present80_iter_core dut (
        .clk(clk), .rst(rst), .start(start), .pt(pt), .key(key),
        .busy(busy), .done(done), .ct(ct)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending encryption.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            check("done_busy_overlap", busy, 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: done=1 with no pending encryption at %0t", $time);
            end else begin
                check("ct_scoreboard", ct, exp_q.pop_front());
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic issue(input logic [63:0] p, input logic [79:0] k,
                         input logic [63:0] exp, input bit push);
        pt    = p;
        key   = k;
        start = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // c0 is the current RUN cycle index (1 = cycle after the accepting edge).
    task automatic wait_done(input string name, input int c0);
        int          cyc      = c0;
        int          bcnt     = 0;
        int          hold_err = 0;
        logic [63:0] ct0      = ct;
        while (done !== 1'b1 && cyc < c0 + 100) begin
            if (busy === 1'b1) bcnt++;
            if (ct !== ct0) hold_err++;
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: no done within 100 cycles", name);
        end else begin
            check({name, "_latency"}, cyc, PER);
            check({name, "_busy_cycles"}, bcnt, LAT - c0 + 1);
            check({name, "_ct_hold"}, hold_err, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int viol, first_done, last_done, spacing_err, dones_in_win, n_acc, w;
        rst = 1'b1; start = 1'b0; pt = '0; key = '0;
        repeat (2) @(negedge clk);
        start = 1'b1;                       // reset must win over start
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ct", ct, 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Basic vectors; the third is issued in the done cycle of the second.
        issue(64'h0, 80'h0, CT_00, 1);
        wait_done("v00", 1);
        @(negedge clk);
        issue(64'h0, ONES80, CT_0F, 1);
        wait_done("v0f", 1);
        issue(ONES64, 80'h0, CT_F0, 1);
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);
        wait_done("vf0", 1);
        @(negedge clk);

        // Inputs change and start pulses mid-run: must not disturb the result.
        issue(ONES64, ONES80, CT_FF, 1);
        repeat (9) @(negedge clk);
        pt = '0; key = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midrun_busy", busy, 1);
        wait_done("vff", 11);
        repeat (40) @(negedge clk);
        check("vff_single_done", n_done, n_push);

        // start held high for 100 cycles: back-to-back runs.
        n_acc = 99 / PER + 1;
        pt = '0; key = '0; start = 1'b1;
        for (int i = 0; i < n_acc; i++) begin
            exp_q.push_back(CT_00);
            n_push++;
        end
        viol = 0; first_done = 0; last_done = 0; spacing_err = 0; dones_in_win = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (busy === done) viol++;
            if (done === 1'b1) begin
                if (dones_in_win == 0) first_done = i;
                else if (i - last_done != PER) spacing_err++;
                last_done = i;
                dones_in_win++;
            end
        end
        start = 1'b0;
        check("hold_busy_vs_done", viol, 0);
        check("hold_first_done", first_done, PER);
        check("hold_spacing", spacing_err, 0);
        check("hold_done_count", dones_in_win, (100 - PER) / PER + 1);
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("hold_drain", exp_q.size(), 0);
        @(negedge clk);
        check("hold_idle_busy", busy, 0);

        // Reset during RUN aborts without a done pulse.
        issue(64'h0, 80'h0, 64'h0, 0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ct", ct, 0);
        repeat (40) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_ct_after", ct, 0);

        // Fresh run after abort, then a second run whose ct must hold the old value.
        issue(64'h0, 80'h0, CT_00, 1);
        wait_done("post_abort", 1);
        issue(ONES64, 80'h0, CT_F0, 1);
        check("ct_before_vf0", ct, CT_00);
        wait_done("vf0_hold", 1);
        repeat (5) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        check("done_total", n_done, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
